// File: rtl/mcl_pkg.sv
// Shared types and elaboration helpers for the MCL EBOX->MBOX request sequencer.
package mcl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        PF   = 2'd3
    } mclState_e;

    // Channel index width; a single requester still gets a 1-bit index.
    function automatic int unsigned chanWidth(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Width of a counter that must be able to hold maxVal.
    function automatic int unsigned cntWidth(input int unsigned maxVal);
        return $clog2(maxVal + 1);
    endfunction

    function automatic bit paramsLegal(input int unsigned nchan,
                                       input int unsigned retryMax,
                                       input int unsigned tmo);
        return (nchan >= 1) && (nchan <= 8) && (retryMax >= 1) && (tmo >= 2);
    endfunction

endpackage

// File: rtl/mcl_rr_arb.sv
// Round-robin one-hot arbiter: grants the first requester at/after the pointer,
// then moves the pointer just past the winner.
module mcl_rr_arb
    import mcl_pkg::*;
#(
    parameter int unsigned NCHAN = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          en,
    input  logic [NCHAN-1:0]              req,
    output logic [NCHAN-1:0]              grant,
    output logic [chanWidth(NCHAN)-1:0]   grantIdx,
    output logic                          grantValid
);

    localparam int unsigned CW = chanWidth(NCHAN);

    logic [CW-1:0] ptr;
    logic [CW-1:0] cand;

    // Scan channels starting at the pointer; first valid one wins.
    always_comb begin
        grant      = '0;
        grantIdx   = '0;
        grantValid = 1'b0;
        cand       = '0;
        if (en) begin
            for (int unsigned i = 0; i < NCHAN; i++) begin
                cand = CW'((32'(ptr) + i) % NCHAN);
                if (!grantValid && req[cand]) begin
                    grant[cand] = 1'b1;
                    grantIdx    = cand;
                    grantValid  = 1'b1;
                end
            end
        end
    end

    // Pointer advances to winner+1 (wrapping) on every grant.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
        end else if (grantValid) begin
            ptr <= (grantIdx == CW'(NCHAN - 1)) ? '0 : grantIdx + 1'b1;
        end
    end

endmodule

// File: rtl/mcl_req_seq.sv
// EBOX->MBOX memory-request sequencer: arbitrates requesters, issues one request
// to CSH/MBOX, handles accept/retry/response, and raises page fails on retry
// exhaustion or response timeout.
module mcl_req_seq
    import mcl_pkg::*;
#(
    parameter int unsigned NCHAN     = 2,
    parameter int unsigned ADDR_W    = 22,
    parameter int unsigned RETRY_MAX = 7,
    parameter int unsigned TMO       = 63
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NCHAN-1:0]              reqValid,
    output logic [NCHAN-1:0]              reqReady,
    input  logic [NCHAN*ADDR_W-1:0]       reqAddr,
    input  logic [NCHAN-1:0]              reqWrite,
    input  logic [NCHAN-1:0]              reqUser,
    input  logic [NCHAN-1:0]              reqPublic,
    output logic                          eboxReqIn,
    output logic [ADDR_W-1:0]             mboxAddr,
    output logic                          mboxWrite,
    output logic                          ptPublic,
    input  logic                          cshEBOXT0,
    input  logic                          cshEBOXRetry,
    input  logic                          mboxRespIn,
    output logic                          mboxXfer,
    output logic [chanWidth(NCHAN)-1:0]   respChan,
    output logic                          eboxSync,
    input  logic                          pfEBOXHandle,
    output logic                          pfHold,
    output logic                          clkForce1777
);

    localparam int unsigned CW = chanWidth(NCHAN);
    localparam int unsigned RW = cntWidth(RETRY_MAX);
    localparam int unsigned TW = cntWidth(TMO);

    if (!paramsLegal(NCHAN, RETRY_MAX, TMO)) begin : gParamCheck
        $error("mcl_req_seq: illegal NCHAN/RETRY_MAX/TMO");
    end

    mclState_e       state, nextState;
    logic [RW-1:0]   retryCnt, retryNext;
    logic [TW-1:0]   timer;
    logic [ADDR_W-1:0] latAddr;
    logic            latWrite, latPublic, latUser;
    logic [CW-1:0]   latChan;
    logic [NCHAN-1:0] grant;
    logic [CW-1:0]   grantIdx;
    logic            grantValid;
    logic            retryHit, retryLimit, tmoHit;

    assign retryNext  = retryCnt + 1'b1;
    assign retryLimit = (retryNext == RW'(RETRY_MAX));
    assign tmoHit     = (timer == TW'(TMO - 1));

    mcl_rr_arb #(.NCHAN(NCHAN)) uArb (
        .clk        (clk),
        .reset      (reset),
        .en         (state == IDLE),
        .req        (reqValid),
        .grant      (grant),
        .grantIdx   (grantIdx),
        .grantValid (grantValid)
    );

    // Next-state and strobes; reset suppresses all combinational pulses.
    always_comb begin
        nextState    = state;
        reqReady     = '0;
        eboxReqIn    = 1'b0;
        mboxXfer     = 1'b0;
        clkForce1777 = 1'b0;
        retryHit     = 1'b0;
        if (!reset) begin
            case (state)
                IDLE: begin
                    if (grantValid) begin
                        reqReady  = grant;
                        nextState = REQ;
                    end
                end
                REQ: begin
                    eboxReqIn = 1'b1;
                    if (cshEBOXRetry) begin
                        retryHit = 1'b1;
                        if (retryLimit) begin
                            nextState    = PF;
                            clkForce1777 = 1'b1;
                        end
                    end else if (cshEBOXT0) begin
                        nextState = WAIT;
                    end
                end
                WAIT: begin
                    if (mboxRespIn) begin
                        mboxXfer  = 1'b1;
                        nextState = IDLE;
                    end else if (cshEBOXRetry) begin
                        retryHit = 1'b1;
                        if (retryLimit) begin
                            nextState    = PF;
                            clkForce1777 = 1'b1;
                        end else begin
                            nextState = REQ;
                        end
                    end else if (tmoHit) begin
                        nextState    = PF;
                        clkForce1777 = 1'b1;
                    end
                end
                PF: begin
                    if (pfEBOXHandle) nextState = IDLE;
                end
                default: nextState = IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= nextState;
    end

    // Request latch, retry counter and response timer.
    always_ff @(posedge clk) begin
        if (reset) begin
            latAddr   <= '0;
            latWrite  <= 1'b0;
            latPublic <= 1'b0;
            latUser   <= 1'b0;
            latChan   <= '0;
            retryCnt  <= '0;
            timer     <= '0;
        end else begin
            if (state == IDLE && grantValid) begin
                latAddr   <= reqAddr[grantIdx*ADDR_W +: ADDR_W];
                latWrite  <= reqWrite[grantIdx];
                latPublic <= reqPublic[grantIdx];
                latUser   <= reqUser[grantIdx];
                latChan   <= grantIdx;
            end
            if (retryHit)                      retryCnt <= retryLimit ? '0 : retryNext;
            else if (state == IDLE || mboxXfer) retryCnt <= '0;
            timer <= (state == WAIT) ? timer + 1'b1 : '0;
        end
    end

    assign mboxAddr  = latAddr;
    assign mboxWrite = latWrite;
    assign respChan  = latChan;
    assign eboxSync  = (state == IDLE);
    assign pfHold    = (state == PF);
    assign ptPublic  = (state != IDLE) && latPublic && latUser;

endmodule

// File: tb/tb_mcl_req_seq.sv
// Scoreboard bench for mcl_req_seq: stimulus pushes expected completions,
// a negedge monitor pops them on mboxXfer / clkForce1777.
module tb_mcl_req_seq;

    localparam int NCHAN     = 2;
    localparam int ADDR_W    = 22;
    localparam int RETRY_MAX = 7;
    localparam int TMO       = 63;

    localparam logic [ADDR_W-1:0] ADDR0 = 22'h001234;
    localparam logic [ADDR_W-1:0] ADDR1 = 22'h2ABCDE;

    logic clk = 1'b0;
    logic reset;
    logic [NCHAN-1:0] reqValid, reqReady, reqWrite, reqUser, reqPublic;
    logic [NCHAN*ADDR_W-1:0] reqAddr;
    logic eboxReqIn, mboxWrite, ptPublic, cshEBOXT0, cshEBOXRetry, mboxRespIn;
    logic mboxXfer, eboxSync, pfEBOXHandle, pfHold, clkForce1777;
    logic [ADDR_W-1:0] mboxAddr;
    logic [0:0] respChan;

    always #5 clk = ~clk;

    mcl_req_seq #(
        .NCHAN(NCHAN), .ADDR_W(ADDR_W), .RETRY_MAX(RETRY_MAX), .TMO(TMO)
    ) dut (
        .clk(clk), .reset(reset), .reqValid(reqValid), .reqReady(reqReady),
        .reqAddr(reqAddr), .reqWrite(reqWrite), .reqUser(reqUser), .reqPublic(reqPublic),
        .eboxReqIn(eboxReqIn), .mboxAddr(mboxAddr), .mboxWrite(mboxWrite), .ptPublic(ptPublic),
        .cshEBOXT0(cshEBOXT0), .cshEBOXRetry(cshEBOXRetry), .mboxRespIn(mboxRespIn),
        .mboxXfer(mboxXfer), .respChan(respChan), .eboxSync(eboxSync),
        .pfEBOXHandle(pfEBOXHandle), .pfHold(pfHold), .clkForce1777(clkForce1777)
    );

    typedef struct {
        bit               isPf;
        logic [0:0]       chan;
        logic [ADDR_W-1:0] addr;
    } exp_t;

    exp_t expQ[$];
    exp_t monE;
    int errors = 0;
    int checks = 0;

    // Per-channel reference values: chan0 user+public write=0, chan1 public only write=1.
    logic [ADDR_W-1:0] addrTab [2];
    logic              ptTab   [2];
    logic              wrTab   [2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every completion or page-fail pulse must match the queue head.
    always @(negedge clk) begin
        if (reset !== 1'b1 && (mboxXfer === 1'b1 || clkForce1777 === 1'b1)) begin
            checks++;
            if (expQ.size() == 0) begin
                errors++;
                $display("FAIL unexpectedCompletion: xfer=%0b force=%0b chan=%0d, none expected",
                         mboxXfer, clkForce1777, respChan);
            end else begin
                monE = expQ.pop_front();
                if (mboxXfer !== ~monE.isPf || clkForce1777 !== monE.isPf ||
                    respChan !== monE.chan || mboxAddr !== monE.addr) begin
                    errors++;
                    $display("FAIL completion: got xfer=%0b force=%0b chan=%0d addr=0x%0h expected pf=%0b chan=%0d addr=0x%0h",
                             mboxXfer, clkForce1777, respChan, mboxAddr, monE.isPf, monE.chan, monE.addr);
                end
            end
        end
    end

    task automatic doReset();
        reset = 1'b1; reqValid = '0; cshEBOXT0 = 1'b0; cshEBOXRetry = 1'b0;
        mboxRespIn = 1'b0; pfEBOXHandle = 1'b0;
        step(); step();
        chk("rstSync",   eboxSync, 1);
        chk("rstReqIn",  eboxReqIn, 0);
        chk("rstPfHold", pfHold, 0);
        chk("rstAddr",   mboxAddr, 0);
        chk("rstMisc",   {mboxWrite, ptPublic, mboxXfer, clkForce1777, respChan}, 0);
        chk("rstReady",  reqReady, 0);
        reset = 1'b0;
    endtask

    // One full grant -> REQ/T0 -> resp transaction; caller has set reqValid.
    task automatic txn(input int c);
        #1;
        chk("grant", reqReady, 32'(1 << c));
        chk("syncIdle", eboxSync, 1);
        expQ.push_back('{1'b0, 1'(c), addrTab[c]});
        step();
        chk("reqIn", eboxReqIn, 1);
        chk("reqAddr", mboxAddr, addrTab[c]);
        chk("reqWrite", mboxWrite, wrTab[c]);
        chk("ptPublic", ptPublic, ptTab[c]);
        chk("syncBusy", eboxSync, 0);
        cshEBOXT0 = 1'b1;
        step();
        cshEBOXT0 = 1'b0;
        chk("waitReqIn", eboxReqIn, 0);
        mboxRespIn = 1'b1;
        #1;
        chk("noGrantOnXfer", reqReady, 0);
        step();
        mboxRespIn = 1'b0;
        chk("syncAfter", eboxSync, 1);
        chk("ptIdle", ptPublic, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        addrTab[0] = ADDR0; addrTab[1] = ADDR1;
        ptTab[0] = 1'b1;    ptTab[1] = 1'b0;
        wrTab[0] = 1'b0;    wrTab[1] = 1'b1;
        reqAddr   = {ADDR1, ADDR0};
        reqWrite  = 2'b10;
        reqUser   = 2'b01;
        reqPublic = 2'b11;

        // Single request on channel 0.
        doReset();
        reqValid = 2'b01;
        txn(0);
        reqValid = '0;

        // Both channels held: alternating grants from pointer 0.
        doReset();
        reqValid = 2'b11;
        txn(0); txn(1); txn(0); txn(1);
        reqValid = '0;

        // T0+Retry together, then retries up to the limit -> page fail.
        reqValid = 2'b01;
        #1;
        chk("pfGrant", reqReady, 2'b01);
        step();
        reqValid = '0;
        cshEBOXRetry = 1'b1;
        for (int r = 1; r <= RETRY_MAX; r++) begin
            if (r == 1) cshEBOXT0 = 1'b1;
            if (r == RETRY_MAX) begin
                expQ.push_back('{1'b1, 1'b0, ADDR0});
                pfEBOXHandle = 1'b1;
            end
            #1;
            chk("retryForce", clkForce1777, 32'(r == RETRY_MAX));
            step();
            cshEBOXT0 = 1'b0;
            if (r < RETRY_MAX) chk("retryReqHeld", eboxReqIn, 1);
        end
        cshEBOXRetry = 1'b0;
        pfEBOXHandle = 1'b0;
        chk("pfHoldSet", pfHold, 1);
        chk("pfReqIn", eboxReqIn, 0);
        reqValid = 2'b11;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("pfNoGrant", reqReady, 0);
            chk("pfHeld", pfHold, 1);
            step();
        end
        reqValid = '0;
        pfEBOXHandle = 1'b1;
        step();
        pfEBOXHandle = 1'b0;
        chk("pfReleased", pfHold, 0);
        chk("pfSync", eboxSync, 1);

        // Response timeout: force pulse exactly TMO cycles after T0.
        reqValid = 2'b10;
        #1;
        chk("tmoGrant", reqReady, 2'b10);
        step();
        reqValid = '0;
        cshEBOXT0 = 1'b1;
        for (int k = 1; k <= TMO; k++) begin
            step();
            if (k == 1) begin
                cshEBOXT0 = 1'b0;
                chk("tmoWaitReqIn", eboxReqIn, 0);
            end
            if (k == TMO - 1) chk("tmoEarly", clkForce1777, 0);
            if (k == TMO) begin
                expQ.push_back('{1'b1, 1'b1, ADDR1});
                chk("tmoForce", clkForce1777, 1);
            end
        end
        step();
        chk("tmoPfHold", pfHold, 1);
        pfEBOXHandle = 1'b1;
        step();
        pfEBOXHandle = 1'b0;
        chk("tmoReleased", pfHold, 0);

        // Response on the timeout cycle completes normally.
        reqValid = 2'b10;
        #1;
        chk("lateGrant", reqReady, 2'b10);
        step();
        reqValid = '0;
        cshEBOXT0 = 1'b1;
        for (int k = 1; k <= TMO; k++) begin
            step();
            if (k == 1) cshEBOXT0 = 1'b0;
        end
        mboxRespIn = 1'b1;
        expQ.push_back('{1'b0, 1'b1, ADDR1});
        #1;
        chk("lateNoForce", clkForce1777, 0);
        chk("lateXfer", mboxXfer, 1);
        step();
        mboxRespIn = 1'b0;
        chk("lateNoPf", pfHold, 0);
        chk("lateSync", eboxSync, 1);

        // Reset while in WAIT with the pointer at 1.
        reqValid = 2'b01;
        #1;
        chk("rstGrant", reqReady, 2'b01);
        step();
        reqValid = '0;
        cshEBOXT0 = 1'b1;
        step();
        cshEBOXT0 = 1'b0;
        chk("rstInWait", eboxSync, 0);
        reset = 1'b1;
        step();
        chk("midRstReqIn", eboxReqIn, 0);
        chk("midRstSync", eboxSync, 1);
        chk("midRstPf", pfHold, 0);
        reset = 1'b0;
        reqValid = 2'b11;
        txn(0);
        reqValid = '0;

        step();
        chk("queueEmpty", expQ.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
